// File: rtl/point_ram_ctrl.sv
// Point memory with write capture from the register file and a valid/ready streaming read port.
// A pass streams mem[first..last] (wrapping modulo depth) to the k-means core, then pulses pass_done.
module point_ram_ctrl #(
    parameter int unsigned addrWidth = 9,
    parameter int unsigned dataWidth = 91
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dataWidth-1:0] wr_data,
    input  logic [dataWidth-1:0] wr_addr,
    input  logic                 w_r_ram_n,
    input  logic                 chip_select_ram_n,
    input  logic [addrWidth-1:0] first_addr,
    input  logic [addrWidth-1:0] last_addr,
    input  logic                 start,
    input  logic                 abort,
    output logic [dataWidth-1:0] pt_data,
    output logic [addrWidth-1:0] pt_index,
    output logic                 pt_valid,
    output logic                 pt_last,
    input  logic                 pt_ready,
    output logic                 pass_done,
    output logic                 busy,
    output logic                 wr_reject
);

    localparam int unsigned Depth = 2 ** addrWidth;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStream,
        StDone
    } state_e;

    state_e               state;
    logic [dataWidth-1:0] mem [Depth];
    logic [addrWidth-1:0] rd_ptr;
    logic [addrWidth-1:0] last_q;
    logic [addrWidth-1:0] wr_idx;
    logic                 wr_req;
    logic                 wr_ok;
    logic                 unused_wr_addr;

    assign wr_req = !chip_select_ram_n && !w_r_ram_n;
    assign wr_ok  = wr_req && (state == StIdle) && !rst;
    assign wr_idx = wr_addr[addrWidth-1:0];
    assign busy   = (state != StIdle);

    // Only the low address bits select a word; the rest of the regfile address is dropped.
    assign unused_wr_addr = ^wr_addr[dataWidth-1:addrWidth];

    // Memory contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            rd_ptr    <= '0;
            last_q    <= '0;
            pt_data   <= '0;
            pt_index  <= '0;
            pt_valid  <= 1'b0;
            pt_last   <= 1'b0;
            pass_done <= 1'b0;
            wr_reject <= 1'b0;
        end else begin
            wr_reject <= wr_req && (state != StIdle);
            pass_done <= 1'b0;
            if (abort && (state != StIdle)) begin
                // Abort wins over start and pt_ready; the pass ends silently.
                state    <= StIdle;
                pt_valid <= 1'b0;
                pt_last  <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (start) begin
                            rd_ptr <= first_addr;
                            last_q <= last_addr;
                            state  <= StFetch;
                        end
                    end
                    StFetch: begin
                        pt_data  <= mem[rd_ptr];
                        pt_index <= rd_ptr;
                        pt_last  <= (rd_ptr == last_q);
                        pt_valid <= 1'b1;
                        state    <= StStream;
                    end
                    StStream: begin
                        if (pt_ready) begin
                            pt_valid <= 1'b0;
                            if (pt_last) begin
                                pt_last   <= 1'b0;
                                pass_done <= 1'b1;
                                state     <= StDone;
                            end else begin
                                rd_ptr <= rd_ptr + addrWidth'(1);
                                state  <= StFetch;
                            end
                        end
                    end
                    StDone: begin
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_point_ram_ctrl.sv
// Self-checking bench for point_ram_ctrl: directed passes plus random ones against an array model.
module tb_point_ram_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 91;
    localparam int DEPTH = 512;

    logic          clk;
    logic          rst;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_addr;
    logic          w_r_ram_n;
    logic          chip_select_ram_n;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic          start;
    logic          abort;
    logic [DW-1:0] pt_data;
    logic [AW-1:0] pt_index;
    logic          pt_valid;
    logic          pt_last;
    logic          pt_ready;
    logic          pass_done;
    logic          busy;
    logic          wr_reject;

    logic [DW-1:0] model_mem [DEPTH];
    int            n_checks;
    int            n_fail;

    point_ram_ctrl #(
        .addrWidth(AW),
        .dataWidth(DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_data          (wr_data),
        .wr_addr          (wr_addr),
        .w_r_ram_n        (w_r_ram_n),
        .chip_select_ram_n(chip_select_ram_n),
        .first_addr       (first_addr),
        .last_addr        (last_addr),
        .start            (start),
        .abort            (abort),
        .pt_data          (pt_data),
        .pt_index         (pt_index),
        .pt_valid         (pt_valid),
        .pt_last          (pt_last),
        .pt_ready         (pt_ready),
        .pass_done        (pass_done),
        .busy             (busy),
        .wr_reject        (wr_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic do_write(input logic [DW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        chip_select_ram_n = 1'b0;
        w_r_ram_n         = 1'b0;
        wr_addr           = a;
        wr_data           = d;
        @(negedge clk);
        chip_select_ram_n = 1'b1;
        w_r_ram_n         = 1'b1;
        model_mem[a[AW-1:0]] = d;
    endtask

    // One pass from f to l. Optional: abort after abort_after handshakes, a rejected write
    // during the pass, or a write to address f in the same cycle as start.
    task automatic run_pass(input int f, input int l, input int ready_pct, input int abort_after,
                            input bit rej_write, input bit with_wr, input logic [DW-1:0] wd);
        int n;
        int k;
        int cyc;
        int idx;
        n = ((l - f + DEPTH) % DEPTH) + 1;
        @(negedge clk);
        first_addr = AW'(f);
        last_addr  = AW'(l);
        start      = 1'b1;
        if (with_wr) begin
            chip_select_ram_n = 1'b0;
            w_r_ram_n         = 1'b0;
            wr_addr           = DW'(f);
            wr_data           = wd;
            model_mem[f]      = wd;
        end
        @(negedge clk);
        start             = 1'b0;
        chip_select_ram_n = 1'b1;
        w_r_ram_n         = 1'b1;
        first_addr        = AW'($urandom);
        last_addr         = AW'($urandom);
        check("fetch_busy", busy, 1);
        check("fetch_no_valid", pt_valid, 0);
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 20 * n + 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("latency_valid", pt_valid, 1);
            if (rej_write && cyc == 2) begin
                check("wr_reject_pulse", wr_reject, 1);
                chip_select_ram_n = 1'b1;
                w_r_ram_n         = 1'b1;
            end
            if (rej_write && cyc == 3) check("wr_reject_one_cycle", wr_reject, 0);
            if (pt_valid) begin
                idx = (f + k) % DEPTH;
                check("pt_index", pt_index, idx);
                check("pt_data", pt_data, model_mem[idx]);
                check("pt_last", pt_last, k == n - 1);
            end
            check("no_early_done", pass_done, 0);
            if (abort_after >= 0 && k == abort_after && pt_valid) begin
                abort    = 1'b1;
                pt_ready = 1'b1;
                @(negedge clk);
                abort    = 1'b0;
                pt_ready = 1'b0;
                check("abort_valid", pt_valid, 0);
                check("abort_busy", busy, 0);
                @(negedge clk);
                check("abort_no_done", pass_done, 0);
                return;
            end
            pt_ready = ($urandom_range(99) < ready_pct);
            if (rej_write && cyc == 1) begin
                chip_select_ram_n = 1'b0;
                w_r_ram_n         = 1'b0;
                wr_addr           = DW'(2);
                wr_data           = rnd_word();
            end
            if (pt_valid && pt_ready) k++;
        end
        check("pass_complete", k, n);
        if (k == n) begin
            @(negedge clk);
            pt_ready = 1'b0;
            check("done_pulse", pass_done, 1);
            check("done_valid_low", pt_valid, 0);
            @(negedge clk);
            check("done_one_cycle", pass_done, 0);
            check("idle_after_done", busy, 0);
        end else begin
            pt_ready = 1'b0;
            abort    = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        int f;
        int l;
        logic [DW-1:0] hi_addr;
        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b1;
        wr_data           = '0;
        wr_addr           = '0;
        w_r_ram_n         = 1'b1;
        chip_select_ram_n = 1'b1;
        first_addr        = '0;
        last_addr         = '0;
        start             = 1'b0;
        abort             = 1'b0;
        pt_ready          = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", pt_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", pass_done, 0);
        check("rst_data", pt_data, 0);
        check("rst_reject", wr_reject, 0);
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) do_write(DW'(a), rnd_word());

        // Single-word pass
        do_write(DW'(3), DW'(8'h5A));
        run_pass(3, 3, 100, -1, 1'b0, 1'b0, '0);

        // Four words with random back-pressure
        for (int a = 0; a < 4; a++) do_write(DW'(a), DW'(10 + a));
        run_pass(0, 3, 50, -1, 1'b0, 1'b0, '0);

        // Wrap through the top of memory
        run_pass(510, 1, 70, -1, 1'b0, 1'b0, '0);

        // Write while busy is dropped; next pass still sees 12 at address 2
        run_pass(0, 3, 60, -1, 1'b1, 1'b0, '0);
        run_pass(0, 3, 100, -1, 1'b0, 1'b0, '0);

        // Abort after two handshakes, then a full pass
        run_pass(8, 11, 100, 2, 1'b0, 1'b0, '0);
        run_pass(8, 11, 100, -1, 1'b0, 1'b0, '0);

        // Reset in the middle of streaming
        @(negedge clk);
        first_addr = AW'(0);
        last_addr  = AW'(3);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", pt_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", pt_valid, 0);
        check("midrst_data", pt_data, 0);
        check("midrst_index", pt_index, 0);
        check("midrst_last", pt_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", pass_done, 0);
        run_pass(0, 3, 100, -1, 1'b0, 1'b0, '0);

        // Upper address bits ignored; read request is a no-op
        hi_addr = '0;
        hi_addr[40] = 1'b1;
        hi_addr[AW-1:0] = AW'(5);
        do_write(hi_addr, DW'(32'hCAFE_0005));
        @(negedge clk);
        chip_select_ram_n = 1'b0;
        w_r_ram_n         = 1'b1;
        wr_addr           = DW'(5);
        wr_data           = rnd_word();
        @(negedge clk);
        chip_select_ram_n = 1'b1;
        run_pass(5, 5, 100, -1, 1'b0, 1'b0, '0);

        // Write and start in the same cycle: the pass sees the new word
        run_pass(20, 22, 80, -1, 1'b0, 1'b1, rnd_word());

        // Abort while idle has no effect
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", pass_done, 0);

        for (int i = 0; i < 6; i++) begin
            f = int'($urandom_range(DEPTH - 1));
            l = (f + int'($urandom_range(15))) % DEPTH;
            run_pass(f, l, int'($urandom_range(100, 30)), -1, 1'b0, 1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
